alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one external combinational ALU (IDLE/EXEC/RESP)
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority, port 0 wins.
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req0_op,
   input  logic [2:0]  req1_op,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   input  logic        rsp0_ready,
   input  logic        rsp1_ready,
   output logic [31:0] rsp_result,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_result,
   output logic [15:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic        gnt_q, gnt_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic [15:0] op_count_q, op_count_d;
   logic        any_req;
   logic        accept;
   logic        sel;
   logic        rsp_hs;

   assign any_req = req0_valid | req1_valid;
   assign accept  = (state_q == IDLE) && any_req;
   assign rsp_hs  = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_RR_EN
   // rr_ptr_q names the port favoured on a tie; it flips away from whoever was last granted
   logic rr_ptr_q, rr_ptr_d;

   always_comb begin
      if (req0_valid && req1_valid) sel = rr_ptr_q;
      else                          sel = ~req0_valid;
      rr_ptr_d = accept ? ~sel : rr_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_q <= 1'b0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`else
   always_comb sel = ~req0_valid;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = accept && !sel;
      req1_ready = accept && sel;
      rsp0_valid = (state_q == RESP) && !gnt_q;
      rsp1_valid = (state_q == RESP) && gnt_q;
   end

   always_comb begin
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      gnt_d        = gnt_q;
      rsp_result_d = rsp_result_q;
      op_count_d   = op_count_q;
      if (accept) begin
         gnt_d = sel;
         a_d   = sel ? req1_a  : req0_a;
         b_d   = sel ? req1_b  : req0_b;
         op_d  = sel ? req1_op : req0_op;
      end
      if (state_q == EXEC) rsp_result_d = alu_result;
      if (rsp_hs)          op_count_d   = op_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         gnt_q        <= 1'b0;
         rsp_result_q <= '0;
         op_count_q   <= '0;
      end else begin
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         gnt_q        <= gnt_d;
         rsp_result_q <= rsp_result_d;
         op_count_q   <= op_count_d;
      end
   end

   // ALU operands come only from the latched registers, never straight from the request ports
   assign alu_srcA    = a_q;
   assign alu_srcB    = b_q;
   assign alu_control = op_q;
   assign rsp_result  = rsp_result_q;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a transaction-level model
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        v0, v1, rr0, rr1;
   logic [31:0] a0, b0, a1, b1;
   logic [2:0]  op0, op1;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp_result, alu_srcA, alu_srcB, alu_result;
   logic [2:0]  alu_control;
   logic [15:0] op_count;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(v0), .req1_valid(v1),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
      .req0_op(op0), .req1_op(op1),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rr0), .rsp1_ready(rr1),
      .rsp_result(rsp_result),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
      .alu_result(alu_result),
      .op_count(op_count)
   );

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      case (op)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b111:  return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_srcA, alu_srcB, alu_control);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 waiting, 1 computing, 2 presenting a result
   int          m_phase = 0;
   logic        m_gnt   = 1'b0;
   logic        m_pref  = 1'b0;
   logic [31:0] m_a = '0, m_b = '0, m_rsp = '0;
   logic [2:0]  m_op = '0;
   logic [15:0] m_cnt = '0;
   int          grant_q[$];

   logic [1:0]  rdy_s, rspv_s;
   logic [31:0] res_s;
   logic [15:0] cnt_s;

   task automatic cycle();
      logic [1:0] exp_rdy, exp_rspv;
      logic       hs;
      @(negedge clk);
      exp_rdy = 2'b00;
      if (m_phase == 0) begin
         if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            exp_rdy = m_pref ? 2'b10 : 2'b01;
`else
            exp_rdy = 2'b01;
`endif
         end else begin
            exp_rdy = {v1, v0};
         end
      end
      exp_rspv = (m_phase == 2) ? (m_gnt ? 2'b10 : 2'b01) : 2'b00;
      chk("ready",  32'({req1_ready, req0_ready}), 32'(exp_rdy));
      chk("rspv",   32'({rsp1_valid, rsp0_valid}), 32'(exp_rspv));
      chk("result", rsp_result, m_rsp);
      chk("count",  32'(op_count), 32'(m_cnt));
      chk("srcA",   alu_srcA, m_a);
      chk("srcB",   alu_srcB, m_b);
      chk("ctl",    32'(alu_control), 32'(m_op));
      rdy_s  = {req1_ready, req0_ready};
      rspv_s = {rsp1_valid, rsp0_valid};
      res_s  = rsp_result;
      cnt_s  = op_count;
      hs = (m_phase == 2) && (m_gnt ? rr1 : rr0);
      @(posedge clk);
      #1;
      if (reset) begin
         m_phase = 0; m_gnt = 1'b0; m_pref = 1'b0;
         m_a = '0; m_b = '0; m_op = '0; m_rsp = '0; m_cnt = '0;
      end else if (m_phase == 0) begin
         if (exp_rdy != 2'b00) begin
            m_gnt  = exp_rdy[1];
            m_pref = ~m_gnt;
            grant_q.push_back(int'(m_gnt));
            if (m_gnt) begin m_a = a1; m_b = b1; m_op = op1; v1 = 1'b0; end
            else       begin m_a = a0; m_b = b0; m_op = op0; v0 = 1'b0; end
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_rsp   = alu_fn(m_a, m_b, m_op);
         m_phase = 2;
      end else if (hs) begin
         m_phase = 0;
         m_cnt   = m_cnt + 16'd1;
      end
   endtask

   task automatic refill();
      if (!v0) begin v0 = 1'b1; a0 = $urandom; b0 = $urandom; op0 = 3'($urandom_range(0, 7)); end
      if (!v1) begin v1 = 1'b1; a1 = $urandom; b1 = $urandom; op1 = 3'($urandom_range(0, 7)); end
   endtask

   task automatic one_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] exp, input string tag);
      rr0 = 1'b1; rr1 = 1'b1;
      if (!p) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
      else    begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
      cycle();
      chk({tag, "_rdy"}, 32'(rdy_s), p ? 32'd2 : 32'd1);
      cycle();
      chk({tag, "_exec_rspv"}, 32'(rspv_s), 32'd0);
      cycle();
      chk({tag, "_rspv"}, 32'(rspv_s), p ? 32'd2 : 32'd1);
      chk({tag, "_res"}, res_s, exp);
   endtask

   initial begin
      reset = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
      @(posedge clk);
      #1;
      cycle();
      chk("rst_rdy", 32'(rdy_s), 32'd0);
      chk("rst_cnt", 32'(cnt_s), 32'd0);
      reset = 1'b0;
      cycle();

      one_op(1'b0, 32'd5, 32'd7, 3'b010, 32'd12, "add");
      cycle();
      chk("add_cnt", 32'(cnt_s), 32'd1);
      one_op(1'b1, 32'd3, 32'd5, 3'b110, 32'hFFFF_FFFE, "sub");
      one_op(1'b0, 32'd2, 32'hFFFF_FFFF, 3'b111, 32'd1, "sltu");
      one_op(1'b1, 32'd9, 32'd4, 3'b011, 32'd0, "undef");

      reset = 1'b1;
      cycle();
      reset = 1'b0;
      grant_q.delete();
      rr0 = 1'b1; rr1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         refill();
         cycle();
      end
      chk("gnt_n", 32'(grant_q.size()), 32'd4);
      for (int i = 0; i < grant_q.size(); i++) begin
`ifdef ALU_ARB_RR_EN
         chk($sformatf("gnt_seq%0d", i), 32'(grant_q[i]), 32'(i % 2));
`else
         chk($sformatf("gnt_seq%0d", i), 32'(grant_q[i]), 32'd0);
`endif
      end
      v0 = 1'b0; v1 = 1'b0;
      cycle();

      v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 3'b010;
      v1 = 1'b1; a1 = 32'd40; b1 = 32'd2; op1 = 3'b110;
      rr0 = 1'b0; rr1 = 1'b1;
      cycle();
      chk("stall_gnt", 32'(rdy_s), 32'd1);
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_rspv", 32'(rspv_s), 32'd1);
         chk("stall_res", res_s, 32'd3);
         chk("stall_rdy", 32'(rdy_s), 32'd0);
      end
      rr0 = 1'b1;
      cycle();
      cycle();
      chk("after_stall_gnt", 32'(rdy_s), 32'd2);
      cycle();
      cycle();
      chk("p1_res", res_s, 32'd38);

      v0 = 1'b1; a0 = 32'd8; b0 = 32'd8; op0 = 3'b010;
      cycle();
      reset = 1'b1; v0 = 1'b0;
      cycle();
      reset = 1'b0;
      cycle();
      chk("abort_rspv", 32'(rspv_s), 32'd0);
      chk("abort_rdy", 32'(rdy_s), 32'd0);
      chk("abort_cnt", 32'(cnt_s), 32'd0);

      m_cnt = 16'hFFFF;
      force dut.op_count_q = 16'hFFFF;
      cycle();
      release dut.op_count_q;
      chk("cnt_pre", 32'(cnt_s), 32'h0000_FFFF);
      one_op(1'b0, 32'd1, 32'd1, 3'b010, 32'd2, "wrap_op");
      cycle();
      chk("cnt_wrap", 32'(cnt_s), 32'd0);

      for (int i = 0; i < 1500; i++) begin
         if (!v0 && $urandom_range(0, 2) == 0) begin
            v0 = 1'b1; op0 = 3'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         end
         if (!v1 && $urandom_range(0, 2) == 0) begin
            v1 = 1'b1; op1 = 3'($urandom_range(0, 7));
            a1 = $urandom; b1 = $urandom;
         end
         rr0 = ($urandom_range(0, 3) != 0);
         rr1 = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 199) == 0);
         if (reset) begin v0 = 1'b0; v1 = 1'b0; end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
